// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M mul/div unit.
`timescale 1ns/1ps
interface rv32m_muldiv_if;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rv1_i;
  logic [31:0] rv2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output start_i, funct3_i, rv1_i, rv2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, rv1_i, rv2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/rv32m_muldiv.sv
// Sequential RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional macro RV32M_FAST_MUL_EN: single-cycle combinational multiplies.
`timescale 1ns/1ps
module rv32m_muldiv (
  input  logic          clk,
  input  logic          rst_n,
  rv32m_muldiv_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned DLEN = 2 * XLEN;
  localparam int unsigned CW   = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [DLEN-1:0] acc_q, acc_d;
  logic            neg1_q, neg1_d;
  logic            neg2_q, neg2_d;
  logic            fast_q, fast_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode at the accept boundary
  logic            accept_c;
  logic            sgn1_c, sgn2_c;
  logic            neg1_c, neg2_c;
  logic [XLEN-1:0] mag1_c, mag2_c;
  logic            div_zero_c, div_ovf_c;

  assign accept_c   = bus.start_i && !busy_q && !bus.flush_i;
  assign sgn1_c     = !(bus.funct3_i inside {OP_MULHU, OP_DIVU, OP_REMU});
  assign sgn2_c     = sgn1_c && (bus.funct3_i != OP_MULHSU);
  assign neg1_c     = sgn1_c && bus.rv1_i[XLEN-1];
  assign neg2_c     = sgn2_c && bus.rv2_i[XLEN-1];
  assign mag1_c     = neg1_c ? XLEN'(-bus.rv1_i) : bus.rv1_i;
  assign mag2_c     = neg2_c ? XLEN'(-bus.rv2_i) : bus.rv2_i;
  assign div_zero_c = bus.funct3_i[2] && (bus.rv2_i == '0);
  assign div_ovf_c  = bus.funct3_i[2] && !bus.funct3_i[0] &&
                      (bus.rv1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rv2_i == '1);

`ifdef RV32M_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a_c, fm_b_c;
  logic signed [2*XLEN+1:0] fm_prod_c;
  assign fm_a_c    = $signed({sgn1_c && bus.rv1_i[XLEN-1], bus.rv1_i});
  assign fm_b_c    = $signed({sgn2_c && bus.rv2_i[XLEN-1], bus.rv2_i});
  assign fm_prod_c = fm_a_c * fm_b_c;
`endif

  // One multiply step: add multiplicand if multiplier LSB set, shift right
  logic [XLEN:0]   mul_sum_c;
  logic [DLEN-1:0] mul_step_c;
  assign mul_sum_c  = {1'b0, acc_q[DLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : (XLEN+1)'(0));
  assign mul_step_c = {mul_sum_c, acc_q[XLEN-1:1]};

  // One restoring divide step: remainder in upper half, dividend/quotient in lower
  logic [XLEN:0]   div_rem_c, div_diff_c;
  logic [DLEN-1:0] div_step_c;
  assign div_rem_c  = {acc_q[DLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff_c = div_rem_c - {1'b0, opb_q};
  assign div_step_c = div_diff_c[XLEN] ? {div_rem_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                       : {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sign fix-up; fast-path results are stored final and bypass it
  logic            fix_c;
  logic [DLEN-1:0] prod_c;
  logic [XLEN-1:0] quot_c, rem_c, fin_c;
  assign fix_c  = !fast_q;
  assign prod_c = (fix_c && (neg1_q ^ neg2_q)) ? DLEN'(-acc_q) : acc_q;
  assign quot_c = (fix_c && (neg1_q ^ neg2_q)) ? XLEN'(-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
  assign rem_c  = (fix_c && neg1_q) ? XLEN'(-acc_q[DLEN-1:XLEN]) : acc_q[DLEN-1:XLEN];
  assign fin_c  = op_q[2] ? (op_q[1] ? rem_c : quot_c)
                          : ((op_q == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[DLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    fast_d   = fast_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d    = bus.funct3_i;
          neg1_d  = neg1_c;
          neg2_d  = neg2_c;
          opb_d   = mag2_c;
          acc_d   = {{XLEN{1'b0}}, mag1_c};
          fast_d  = 1'b0;
          cnt_d   = CW'(XLEN);
          state_d = ST_CALC;
          if (div_zero_c) begin
            acc_d   = {bus.rv1_i, {XLEN{1'b1}}};
            fast_d  = 1'b1;
            state_d = ST_FIN;
          end else if (div_ovf_c) begin
            acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            fast_d  = 1'b1;
            state_d = ST_FIN;
          end
`ifdef RV32M_FAST_MUL_EN
          else if (!bus.funct3_i[2]) begin
            acc_d   = fm_prod_c[DLEN-1:0];
            fast_d  = 1'b1;
            state_d = ST_FIN;
          end
`endif
        end
      end
      ST_CALC: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = op_q[2] ? div_step_c : mul_step_c;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        if (!bus.flush_i) begin
          result_d = fin_c;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      fast_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      fast_q   <= fast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed and randomized checks of rv32m_muldiv against an arithmetic reference model.
`timescale 1ns/1ps
module tb_rv32m_muldiv;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [31:0] last_res;

  rv32m_muldiv_if bus ();

  rv32m_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      p;
    logic [63:0] pu;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f >= 3'd4 && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RV32M_FAST_MUL_EN
    if (f < 3'd4) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a request now; accept is the next rising edge. Returns with done sampled.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int n;
    int lat;
    lat = ref_latency(f, a, b);
    bus.start_i  = 1'b1;
    bus.funct3_i = f;
    bus.rv1_i    = a;
    bus.rv2_i    = b;
    @(posedge clk);
    #1;
    bus.start_i  = 1'b0;
    bus.funct3_i = 3'($urandom);
    bus.rv1_i    = $urandom;
    bus.rv2_i    = $urandom;
    chk({tag, ".busy_after_accept"}, 32'(bus.busy_o), 32'd1);
    chk({tag, ".no_early_done"}, 32'(bus.done_o), 32'd0);
    n = 0;
    while (!bus.done_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".result"}, bus.result_o, exp);
    chk({tag, ".busy_at_done"}, 32'(bus.busy_o), 32'd0);
    last_res = exp;
  endtask

  initial begin
    int dn;
    n_assert     = 0;
    n_fail       = 0;
    last_res     = '0;
    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.funct3_i = '0;
    bus.rv1_i    = '0;
    bus.rv2_i    = '0;
    bus.flush_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(bus.busy_o), 32'd0);
    chk("reset.done", 32'(bus.done_o), 32'd0);
    chk("reset.result", bus.result_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    do_op("mul_10x10", 3'd0, 32'd10, 32'd10, 32'd100);
    do_op("mul_5x10", 3'd0, 32'd5, 32'd10, 32'd50);
    @(negedge clk);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("divu_10_5", 3'd5, 32'd10, 32'd5, 32'd2);
    do_op("remu_10_5", 3'd7, 32'd10, 32'd5, 32'd0);
    do_op("divu_by0", 3'd5, 32'd10, 32'd0, 32'hFFFF_FFFF);
    do_op("remu_by0", 3'd7, 32'd10, 32'd0, 32'd10);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    do_op("rem_by0_neg", 3'd6, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);

    // Flush mid-divide: no done, result keeps the previous value
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'd4;
    bus.rv1_i    = 32'd100;
    bus.rv2_i    = 32'd7;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    chk("flush.busy", 32'(bus.busy_o), 32'd0);
    chk("flush.done", 32'(bus.done_o), 32'd0);
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o) dn++;
    end
    chk("flush.no_done_after", 32'(dn), 32'd0);
    chk("flush.result_held", bus.result_o, last_res);
    @(negedge clk);
    do_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'd4;
    bus.rv1_i    = 32'hFFFF_FFF9;
    bus.rv2_i    = 32'd2;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.busy", 32'(bus.busy_o), 32'd0);
    chk("areset.done", 32'(bus.done_o), 32'd0);
    chk("areset.result", bus.result_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst_divu", 3'd5, 32'd1000, 32'd3, 32'd333);
    do_op("b2b_mul", 3'd0, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFF2);

    // Randomized operations, mixing back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_result(f, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32m_muldiv.md
# rv32m_muldiv

Sequential execution unit for the RV32M extension: accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per handshake from the execute stage, computes it over multiple cycles, and returns a 32-bit result with a one-cycle done pulse. It sits beside the integer ALU and is driven by the same decoded funct3 and rv1/rv2 operand values that the instruction bus carries.

## Interface
- No parameters.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  request; accepted on a rising edge when start_i=1 and busy_o=0
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rv1_i  in  32  operand 1, sampled only at accept
- rv2_i  in  32  operand 2, sampled only at accept
- flush_i  in  1  synchronous abort of the in-flight operation
- busy_o  out  1  operation in flight; reset 0
- done_o  out  1  one-cycle pulse, result_o valid; reset 0
- result_o  out  32  result, held from done_o until the next done_o; reset 0

## Operation
- States: IDLE, CALC, FIN. Reset enters IDLE. 6-bit iteration counter, reset 0.
- IDLE: on accept, latch funct3, operand magnitudes, and sign flags. If fast-path, go to FIN; otherwise go to CALC with counter=32.
- Signedness: MUL/MULH/DIV/REM signed x signed; MULHSU rv1 signed, rv2 unsigned; MULHU/DIVU/REMU unsigned.
- Multiply: unsigned shift-add on 32-bit magnitudes into a 64-bit accumulator, one bit per CALC cycle. In FIN, negate the 64-bit product if the operand signs differ. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
- Divide: restoring, one quotient bit per CALC cycle on magnitudes. In FIN, negate the quotient if the signs differ (signed ops). The remainder takes the dividend's sign.
- CALC: one iteration per edge, counter decrements; at counter=1 the next state is FIN.
- FIN: register result_o, pulse done_o, return to IDLE.
- Fast path (no CALC):
  - divide by zero: DIV/DIVU=0xFFFFFFFF, REM/REMU=rv1.
  - signed overflow (DIV with rv1=0x80000000, rv2=0xFFFFFFFF): quotient 0x80000000, REM 0.
  - multiply when RV32M_FAST_MUL_EN is defined.
- flush_i=1 in CALC or FIN: return to IDLE, no done_o, result_o unchanged. flush_i=1 in IDLE blocks that cycle's accept.
- Asynchronous reset mid-operation: immediate IDLE, all outputs 0.
- The operand inputs may change freely after accept.

## Timing
- Accept edge E0. Iterative ops: CALC on E1..E32, FIN on E33. done_o and result_o are valid after E33. Latency is 33 cycles.
- Fast path: FIN on E1, so done_o is valid after E1. Latency is 1 cycle.
- busy_o=1 from after E0 until after the FIN edge, when it falls as done_o rises.
- Back-to-back operation: a start_i asserted during the done_o cycle is accepted on that edge.

## Configuration
- RV32M_FAST_MUL_EN defined: all four multiplies use a combinational 33x33 signed product and take the fast path (1-cycle latency). Divides are unchanged.
- RV32M_FAST_MUL_EN undefined: multiplies are iterative with 33-cycle latency. No hardware multiplier is inferred.

## Test plan
- MUL rv1=10, rv2=10 -> result_o=100 (0x64), done_o after 33 cycles (1 cycle with the macro); then MUL rv1=5 -> 50.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 10/5 -> 2; REMU 10%5 -> 0; each with done_o after 33 cycles.
- DIVU 10/0 -> 0xFFFFFFFF and REMU 10%0 -> 10, done_o 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0.
- DIV accepted, flush_i pulsed at E10 -> no done_o, busy_o=0 next cycle; a new MUL 3x4 is then accepted -> 12.
- rst_n low at E15 of a DIV -> busy_o, done_o, and result_o read 0 immediately; after release, a start_i in the done_o cycle of a new op is accepted back-to-back.
